// File: rtl/dynamics.sv
// Amplitude-envelope stage: scales a signed sample by an unsigned Q1.7 gain once
// the note's envelope position reaches the start point, saturating to the sample range.
module dynamics #(
  parameter int SW = 16,
  parameter int GW = 8,
  parameter int PW = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [SW-1:0] sample_in,
  input  logic        [PW-1:0] curr,
  input  logic        [PW-1:0] start,
  input  logic        [GW-1:0] multiple,
  output logic signed [SW-1:0] sample_out
);

  // The product of a signed SW-bit sample and a zero-extended GW-bit gain needs SW+GW+1 bits.
  localparam int PRW = SW + GW + 1;

  localparam logic signed [PRW-1:0] C_MAX = {{(GW + 2){1'b0}}, {(SW - 1){1'b1}}};
  localparam logic signed [PRW-1:0] C_MIN = {{(GW + 2){1'b1}}, {(SW - 1){1'b0}}};

  logic                  w_en;
  logic signed [PRW-1:0] w_sample_ext;
  logic signed [PRW-1:0] w_gain_ext;
  logic signed [PRW-1:0] w_product;
  logic signed [PRW-1:0] w_shifted;
  logic signed [SW-1:0]  new_sample;
  logic signed [SW-1:0]  r_sample_out;

  assign w_en         = (curr >= start);
  assign w_sample_ext = {{(GW + 1){sample_in[SW-1]}}, sample_in};
  assign w_gain_ext   = {{(SW + 1){1'b0}}, multiple};
  assign w_product    = w_sample_ext * w_gain_ext;
  // Arithmetic shift floors toward -infinity; no rounding is applied.
  assign w_shifted    = w_product >>> (GW - 1);

  // NOTE: new_sample gets a value before any branch so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    new_sample = sample_in;
    if (w_en) begin
      if (w_shifted > C_MAX) begin
        new_sample = C_MAX[SW-1:0];
      end else if (w_shifted < C_MIN) begin
        new_sample = C_MIN[SW-1:0];
      end else begin
        new_sample = w_shifted[SW-1:0];
      end
    end
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking assignments here would create ordering races.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sample_out <= '0;
    end else begin
      r_sample_out <= new_sample;
    end
  end

  assign sample_out = r_sample_out;

endmodule

// File: tb/tb_dynamics.sv
// Scoreboard bench for dynamics: the driver pushes model results per cycle, and a
// monitor pops one result after every rising edge and compares it with sample_out.
module tb_dynamics;

  logic               clk;
  logic               rst;
  logic signed [15:0] sample_in;
  logic        [4:0]  curr;
  logic        [4:0]  start;
  logic        [7:0]  multiple;
  logic signed [15:0] sample_out;

  typedef struct {
    logic [15:0] value;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  dynamics dut (
    .clk        (clk),
    .rst        (rst),
    .sample_in  (sample_in),
    .curr       (curr),
    .start      (start),
    .multiple   (multiple),
    .sample_out (sample_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: integer product, floor division by 128, clamp to 16-bit signed range.
  function automatic logic [15:0] ref_model(input logic r, input logic [15:0] s,
                                            input logic [4:0] c, input logic [4:0] st,
                                            input logic [7:0] m);
    int si;
    int p;
    int q;
    if (r) return 16'h0000;
    if (int'(c) < int'(st)) return s;
    si = int'($signed(s));
    p  = si * int'(m);
    if (p >= 0) q = p / 128;
    else        q = -((-p + 127) / 128);
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return q[15:0];
  endfunction

  task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, actual, expected);
    end
  endtask

  task automatic drive(input logic r, input logic [15:0] s, input logic [4:0] c,
                       input logic [4:0] st, input logic [7:0] m, input string name);
    exp_t e;
    @(negedge clk);
    rst       = r;
    sample_in = s;
    curr      = c;
    start     = st;
    multiple  = m;
    e.value   = ref_model(r, s, c, st, m);
    e.name    = name;
    exp_q.push_back(e);
  endtask

  // Monitor: one output per cycle, compared against the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.name, sample_out, e.value);
      end
    end
  end

  initial begin
    int drain;
    rst       = 1'b1;
    sample_in = '0;
    curr      = '0;
    start     = '0;
    multiple  = '0;

    drive(1'b1, 16'h1555, 5'd31, 5'd10, 8'h80, "reset");
    drive(1'b0, 16'h1555, 5'd31, 5'd10, 8'h80, "unity");
    drive(1'b0, 16'h1555, 5'd31, 5'd10, 8'h7D, "decay_7d");
    drive(1'b0, 16'h1555, 5'd31, 5'd10, 8'h40, "decay_40");
    drive(1'b0, 16'h1555, 5'd31, 5'd10, 8'h22, "decay_22");
    drive(1'b0, 16'hEAAA, 5'd31, 5'd10, 8'h40, "neg_half");
    drive(1'b0, 16'hFFFF, 5'd31, 5'd10, 8'h40, "neg_floor");
    drive(1'b0, 16'h7FFF, 5'd31, 5'd10, 8'hFF, "sat_pos");
    drive(1'b0, 16'h8000, 5'd31, 5'd10, 8'hFF, "sat_neg");
    drive(1'b0, 16'h4000, 5'd31, 5'd10, 8'hFF, "no_sat");
    drive(1'b0, 16'h1555, 5'd9,  5'd10, 8'h40, "bypass_below");
    drive(1'b0, 16'h1555, 5'd10, 5'd10, 8'h40, "enable_equal");
    drive(1'b0, 16'h1555, 5'd0,  5'd0,  8'h40, "enable_zero");
    drive(1'b0, 16'h1555, 5'd31, 5'd10, 8'h00, "gain_zero");
    drive(1'b1, 16'h7FFF, 5'd31, 5'd10, 8'hFF, "reset_mid");
    drive(1'b0, 16'h8000, 5'd31, 5'd0,  8'hFF, "post_reset");

    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 63) == 0), 16'($urandom), 5'($urandom), 5'($urandom),
            8'($urandom), "random");
    end

    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    #2;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: %0d outputs pending, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
